rd_burst_arbiter: RTL and testbench

// - Shares one 64-bit AXI-style read master among Np input_cache burst requesters (rreq/rack/radr).
// - Sits between the per-channel input caches of tfacc_core and the DDR read port.
// - Arbitration is round-robin, one whole burst per grant.
// - Adds rbase to each channel's byte offset, issues a fixed-length burst and steers beats back as rack enables.

---
 rtl/tfacc_pkg.sv | 24 ++
 rtl/rd_burst_arbiter_rr_pick.sv | 29 ++
 rtl/rd_burst_arbiter.sv | 130 +++++++++++++
 tb/tb_rd_burst_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tfacc_pkg.sv
// Shared types and constants for the tfacc read-side datapath.
// Holds the read-burst arbiter state encoding and burst sizing.
package tfacc_pkg;

    typedef logic [7:0]  u8_t;
    typedef logic [23:0] u24_t;
    typedef logic [31:0] u32_t;
    typedef logic [63:0] u64_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        GAP
    } rdarb_state_t;

    localparam int RD_BURST_BEATS = 128;

    // The DDR address space is 32-bit; overflow wraps silently.
    function automatic u32_t rdarb_addr(input u32_t base, input u24_t offset);
        return base + {8'h00, offset};
    endfunction

endpackage

// File: rtl/rd_burst_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: starting after the most
// recently served index, returns the first asserted request.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] sel_o,
    output logic          any_o
);

    int idx;

    // Search order is last+1, last+2, ... wrapping, ending on last itself.
    always_comb begin
        sel_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_i) + i) % N;
            if (!any_o && req_i[idx]) begin
                any_o = 1'b1;
                sel_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/rd_burst_arbiter.sv
// Shares one 64-bit read master among Np input-cache burst requesters,
// granting one whole fixed-length burst per channel in round-robin order.
module rd_burst_arbiter
    import tfacc_pkg::*;
#(
    parameter int Np    = 4,
    parameter int BEATS = RD_BURST_BEATS
) (
    input  logic                  aclk,
    input  logic                  arst_n,
    input  logic [31:0]           rbase,
    input  logic [Np-1:0]         rreq,
    input  logic [Np-1:0][23:0]   radr,
    output logic [Np-1:0]         rack,
    output logic [63:0]           rdata,
    output logic [31:0]           m_araddr,
    output logic [7:0]            m_arlen,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [63:0]           m_rdata,
    input  logic                  m_rvalid,
    input  logic                  m_rlast,
    output logic                  m_rready,
    output logic                  busy,
    output logic                  err
);

    localparam int  IW        = (Np > 1) ? $clog2(Np) : 1;
    localparam u8_t LAST_BEAT = u8_t'(BEATS - 1);

    rdarb_state_t  state_q;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] lastGrant_q;
    u32_t          araddr_q;
    u32_t          araddr_d;
    logic          arvalid_q;
    logic          rready_q;
    u8_t           beatCnt_q;
    logic          err_q;
    logic          busy_q;

    logic [IW-1:0] pickSel;
    logic          pickAny;
    logic          lastBeat;

    rr_pick #(
        .N  (Np),
        .IW (IW)
    ) u_rr_pick (
        .req_i  (rreq),
        .last_i (lastGrant_q),
        .sel_o  (pickSel),
        .any_o  (pickAny)
    );

    assign araddr_d = rdarb_addr(rbase, radr[pickSel]);
    assign lastBeat = (beatCnt_q == LAST_BEAT);

    // The burst length is fixed by the count; m_rlast only feeds the error flag.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= IW'(Np - 1);
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            beatCnt_q   <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickAny) begin
                        grant_q   <= pickSel;
                        araddr_q  <= araddr_d;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beatCnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (m_rvalid) begin
                        beatCnt_q <= beatCnt_q + 8'd1;
                        if (m_rlast != lastBeat) begin
                            err_q <= 1'b1;
                        end
                        if (lastBeat) begin
                            rready_q    <= 1'b0;
                            lastGrant_q <= grant_q;
                            state_q     <= GAP;
                        end
                    end
                end
                GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Beats are steered to the granted channel only while a burst is in flight.
    always_comb begin
        rack = '0;
        if (state_q == DATA && m_rvalid) begin
            rack[grant_q] = 1'b1;
        end
    end

    assign rdata     = m_rdata;
    assign m_araddr  = araddr_q;
    assign m_arlen   = LAST_BEAT;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rd_burst_arbiter.sv
// Directed testbench for rd_burst_arbiter: single requests, contention,
// backpressure, rlast error, address wrap and reset mid-burst.
module tb_rd_burst_arbiter;

    localparam int NP    = 4;
    localparam int BEATS = 128;

    logic                 aclk = 1'b0;
    logic                 arst_n;
    logic [31:0]          rbase;
    logic [NP-1:0]        rreq;
    logic [NP-1:0][23:0]  radr;
    logic [NP-1:0]        rack;
    logic [63:0]          rdata;
    logic [31:0]          m_araddr;
    logic [7:0]           m_arlen;
    logic                 m_arvalid;
    logic                 m_arready;
    logic [63:0]          m_rdata;
    logic                 m_rvalid;
    logic                 m_rlast;
    logic                 m_rready;
    logic                 busy;
    logic                 err;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] t2Addr [4];
    int          t2Order[5];

    rd_burst_arbiter #(
        .Np    (NP),
        .BEATS (BEATS)
    ) dut (
        .aclk      (aclk),
        .arst_n    (arst_n),
        .rbase     (rbase),
        .rreq      (rreq),
        .radr      (radr),
        .rack      (rack),
        .rdata     (rdata),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rvalid  (m_rvalid),
        .m_rlast   (m_rlast),
        .m_rready  (m_rready),
        .busy      (busy),
        .err       (err)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expVal);
        checkCount++;
        assert (obs === expVal) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expVal);
    endtask

    // Entered in ADDR one sample after m_arvalid should have risen; leaves in GAP.
    task automatic applyStimulus(input int ch, input logic [31:0] expAddr, input int arDelay,
                                 input bit toggle, input int rlastBeat);
        int            beats;
        int            cycles;
        logic [NP-1:0] expRack;
        logic [63:0]   data;
        checkOutput("arvalid", 64'(m_arvalid), 64'd1);
        checkOutput("araddr", 64'(m_araddr), 64'(expAddr));
        checkOutput("arlen", 64'(m_arlen), 64'd127);
        m_arready = 1'b0;
        for (int i = 0; i < arDelay; i++) begin
            tick();
            checkOutput("araddr_hold", 64'(m_araddr), 64'(expAddr));
            checkOutput("arvalid_hold", 64'(m_arvalid), 64'd1);
        end
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        checkOutput("arvalid_drop", 64'(m_arvalid), 64'd0);
        checkOutput("rready_on", 64'(m_rready), 64'd1);
        beats  = 0;
        cycles = 0;
        while (beats < BEATS && cycles < 4 * BEATS) begin
            m_rvalid = !(toggle && (cycles % 2 == 1));
            data     = {32'(ch), 32'(beats)} ^ 64'hA5A5_0000_0000_5A5A;
            m_rdata  = data;
            m_rlast  = m_rvalid && (beats == rlastBeat);
            #1;
            expRack = '0;
            if (m_rvalid) expRack[ch] = 1'b1;
            checkOutput("rack", 64'(rack), 64'(expRack));
            checkOutput("rdata", rdata, data);
            if (m_rvalid) beats++;
            cycles++;
            tick();
            if (beats < BEATS) checkOutput("rready_mid", 64'(m_rready), 64'd1);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        checkOutput("beat_count", 64'(beats), 64'(BEATS));
        checkOutput("rready_end", 64'(m_rready), 64'd0);
        checkOutput("busy_gap", 64'(busy), 64'd1);
        checkOutput("arvalid_gap", 64'(m_arvalid), 64'd0);
    endtask

    initial begin
        t2Addr  = '{32'h2000_0040, 32'h2000_1040, 32'h2000_2040, 32'h2000_3040};
        t2Order = '{0, 1, 2, 3, 0};

        arst_n    = 1'b0;
        rbase     = '0;
        rreq      = '0;
        radr      = '0;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        tick();
        tick();
        checkOutput("rst_arvalid", 64'(m_arvalid), 64'd0);
        checkOutput("rst_rready", 64'(m_rready), 64'd0);
        checkOutput("rst_rack", 64'(rack), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_araddr", 64'(m_araddr), 64'd0);
        arst_n = 1'b1;
        tick();

        // T1: single request on ch2
        rbase   = 32'h1000_0000;
        radr[2] = 24'h000400;
        rreq    = 4'b0100;
        tick();
        applyStimulus(2, 32'h1000_0400, 0, 1'b0, 127);
        checkOutput("t1_err", 64'(err), 64'd0);
        rreq = '0;
        tick();
        checkOutput("t1_busy_idle", 64'(busy), 64'd0);
        m_rvalid = 1'b1;
        #1;
        checkOutput("idle_rvalid_rack", 64'(rack), 64'd0);
        checkOutput("idle_rready", 64'(m_rready), 64'd0);
        m_rvalid = 1'b0;
        tick();
        checkOutput("t1_no_rearm", 64'(m_arvalid), 64'd0);

        // T2: all four channels requesting from reset
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        rbase  = 32'h2000_0000;
        radr   = {24'h003040, 24'h002040, 24'h001040, 24'h000040};
        rreq   = 4'hF;
        tick();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(t2Order[k], t2Addr[t2Order[k]], 0, 1'b0, 127);
            if (k == 4) rreq = '0;
            tick();
            checkOutput("t2_idle_busy", 64'(busy), 64'd0);
            checkOutput("t2_idle_arvalid", 64'(m_arvalid), 64'd0);
            if (k < 4) tick();
        end

        // T3: address and data backpressure on ch3
        rbase   = 32'h3000_0000;
        radr[3] = 24'h0ABC00;
        rreq    = 4'b1000;
        tick();
        applyStimulus(3, 32'h300A_BC00, 5, 1'b1, 127);
        rreq = '0;
        tick();
        tick();
        checkOutput("t3_err", 64'(err), 64'd0);

        // T4: early rlast on beat 100
        rbase   = 32'h0000_0000;
        radr[1] = 24'h000800;
        rreq    = 4'b0010;
        tick();
        applyStimulus(1, 32'h0000_0800, 0, 1'b0, 100);
        checkOutput("t4_err", 64'(err), 64'd1);
        rreq = '0;
        tick();
        tick();
        checkOutput("t4_err_sticky", 64'(err), 64'd1);

        // T6: 32-bit address wrap; err must survive a clean burst
        rbase   = 32'hFFFF_FF00;
        radr[2] = 24'h000200;
        rreq    = 4'b0100;
        tick();
        applyStimulus(2, 32'h0000_0100, 0, 1'b0, 127);
        rreq = '0;
        tick();
        tick();
        checkOutput("t6_err_sticky", 64'(err), 64'd1);

        // T5: reset at beat 60 of a ch0 burst
        rbase   = 32'h4000_0000;
        radr[0] = 24'h000100;
        rreq    = 4'b0001;
        tick();
        checkOutput("t5_araddr", 64'(m_araddr), 64'h4000_0100);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = 64'(i);
            tick();
        end
        m_rvalid = 1'b1;
        arst_n   = 1'b0;
        rreq     = '0;
        tick();
        checkOutput("t5_rack", 64'(rack), 64'd0);
        checkOutput("t5_rready", 64'(m_rready), 64'd0);
        checkOutput("t5_busy", 64'(busy), 64'd0);
        checkOutput("t5_arvalid", 64'(m_arvalid), 64'd0);
        checkOutput("t5_err_cleared", 64'(err), 64'd0);
        m_rvalid = 1'b0;
        radr[1]  = 24'h000900;
        radr[3]  = 24'h000300;
        rreq     = 4'b1010;
        arst_n   = 1'b1;
        tick();
        applyStimulus(1, 32'h4000_0900, 0, 1'b0, 127);
        rreq = 4'b1000;
        tick();
        tick();
        applyStimulus(3, 32'h4000_0300, 0, 1'b0, 127);
        rreq = '0;
        tick();
        tick();
        checkOutput("t5_final_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
